msg_char_streamer: RTL and testbench
====================================

Name: msg_char_streamer

Overview:
Parametrised successor to the single-message ASCII character sequencer. It streams one of NUM_MSG stored ASCII messages, one byte at a time, over a valid/ready interface. The character rate is programmable, and the block supports one-shot or looping playback with start/stop control. It sits between the top-level input switches and the output byte bus / display driver.

Parameters:
DATA_W, 8, character width in bits (ASCII).
NUM_MSG, 4, number of stored messages. SEL_W = max(1, clog2(NUM_MSG)).
MAX_LEN, 16, maximum message length in characters; must be >= 9. IDX_W = clog2(MAX_LEN).
PRESC_W, 16, width of the pacing-divider input.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
msg_sel  in  SEL_W  message select; sampled on accepted start
start  in  1  single-cycle start request
stop  in  1  abort request; priority over start
loop_en  in  1  repeat message when set; sampled at last-character accept
rate_div  in  PRESC_W  idle cycles between characters; sampled on accepted start
char_out  out  DATA_W  current character
char_valid  out  1  char_out valid
char_ready  in  1  downstream accepts char_out
char_idx  out  IDX_W  index of the current character
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the final byte of a non-looping message

Behaviour:
- Reset (async, active-high) forces state IDLE and all outputs to 0. It also clears the latched sel/rate, the pacing counter and the index.
- Message table, lengths fixed:
  - 0 = "Guatemala" (9)
  - 1 = "Quetzal" (7)
  - 2 = "Zacapa" (6)
  - 3 = "SOY" (3)
  - msg_sel >= NUM_MSG plays message 0.
- FSM states: IDLE, SEND, PACE, plus CHK when the macro is defined.
- IDLE: start=1 && stop=0 at edge N latches msg_sel and rate_div, and sets idx=0. At N+1 the block is in SEND with char_valid=1, char_out = msg[0], busy=1.
- SEND: char_valid held high; char_out and char_idx stay stable until char_valid && char_ready (accept).
- On accept of a non-last character:
  - rate=0: stay in SEND; the next char is presented the following cycle.
  - rate=R>0: char_valid drops; PACE counts R cycles; char_valid rises at accept+1+R.
- On accept of the last character (idx = len-1):
  - loop_en=1: idx wraps to 0 and pacing applies as above.
  - loop_en=0: go to IDLE; done=1 for exactly the next cycle; busy=0.
- stop=1 in any state: next cycle IDLE, char_valid=0, no done pulse. A char accepted in the same cycle as stop counts as delivered.
- start while busy is ignored. start with stop in IDLE: stays IDLE.
- The pacing counter is PRESC_W wide. rate_div changes while busy have no effect.

Optional Feature:
Macro MSG_CHECKSUM_EN.
- Defined: after the last character is accepted (with pacing applied), state CHK presents one extra byte = XOR of all message characters, with the same handshake and char_idx = len. done/loop follow acceptance of this byte.
- Undefined: no CHK state; behaviour exactly as above.

Decomposition:
- Package msg_streamer_pkg holds:
  - state enum
  - message character constants
  - per-message length constants
  - default parameter values
- One natural sub-module, msg_rom: combinational (sel, idx) -> (char, len, last flag). With the macro, it also outputs the per-message XOR checksum as a constant.

Test Plan:
- Reset mid-SEND (msg 0, idx 4) -> next cycle all outputs 0, state IDLE; a new start then gives 'G' (0x47) at idx 0.
- msg_sel=2, rate_div=0, char_ready=1, loop_en=0, start -> 0x5A,0x61,0x63,0x61,0x70,0x61 on 6 consecutive cycles; done pulses 1 cycle after the last byte; busy then low.
- msg_sel=3, rate_div=3, char_ready=1 -> 'S','O','Y' valid 4 cycles apart; char_valid low for 3 cycles between bytes.
- msg_sel=1, char_ready low for 5 cycles on 'e' (idx 2) -> char_out holds 0x65 and idx 2 stable; no byte skipped or repeated.
- msg_sel=3, loop_en=1 -> S,O,Y,S,O,Y...; stop during the second 'O' -> char_valid=0 next cycle, no done.
- MSG_CHECKSUM_EN defined, msg 2 -> after 'a' (0x61) an extra byte 0x28 with char_idx=6, then done.

Source files
------------

// File: rtl/msg_streamer_pkg.sv
// msg_streamer_pkg: shared types and constants for the message character streamer.
// Holds the FSM state enum, the fixed message table (text and lengths), default
// parameter values, and helpers that read one character or a checksum from the table.
// MSG_CHECKSUM_EN adds the CHK state to the enum.
package msg_streamer_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_NUM_MSG = 4;
  localparam int DEF_MAX_LEN = 16;
  localparam int DEF_PRESC_W = 16;

  localparam int MSG_TABLE_N = 4;
  localparam int STR_CHARS   = 9;

`ifdef MSG_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_PACE, S_CHK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_PACE} state_t;
`endif

  localparam int MSG_LEN [MSG_TABLE_N] = '{9, 7, 6, 3};

  // Shorter strings are zero-padded at the MSB end, so character i of a
  // message of length L always sits at bit 8*(L-1-i).
  localparam logic [8*STR_CHARS-1:0] MSG_STR [MSG_TABLE_N] =
    '{"Guatemala", "Quetzal", "Zacapa", "SOY"};

  function automatic logic [7:0] msg_byte(input int m, input int i);
    int mm;
    mm = (m >= 0 && m < MSG_TABLE_N) ? m : 0;
    if (i < 0 || i >= MSG_LEN[mm]) return 8'h00;
    return MSG_STR[mm][8*(MSG_LEN[mm]-1-i) +: 8];
  endfunction

  function automatic logic [7:0] msg_csum(input int m);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < STR_CHARS; i++) x = x ^ msg_byte(m, i);
    return x;
  endfunction

endpackage

// File: rtl/msg_rom.sv
// msg_rom: combinational lookup (sel, idx) -> (char, len, last), plus the per-message
// XOR checksum when MSG_CHECKSUM_EN is defined.
// Ports: i_sel/i_idx in; o_char, o_len, o_last (idx == len-1), o_csum (macro only).
module msg_rom
  import msg_streamer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEL_W  = 2,
  parameter int IDX_W  = 4
) (
  input  logic [SEL_W-1:0]  i_sel,
  input  logic [IDX_W-1:0]  i_idx,
  output logic [DATA_W-1:0] o_char,
  output logic [IDX_W-1:0]  o_len,
`ifdef MSG_CHECKSUM_EN
  output logic [DATA_W-1:0] o_csum,
`endif
  output logic              o_last
);

  int w_m;

  always_comb begin
    // Selections past the stored table fall back to message 0.
    w_m    = (int'(i_sel) < MSG_TABLE_N) ? int'(i_sel) : 0;
    o_char = DATA_W'(msg_byte(w_m, int'(i_idx)));
    o_len  = IDX_W'(MSG_LEN[w_m]);
    o_last = (i_idx == o_len - 1'b1);
`ifdef MSG_CHECKSUM_EN
    o_csum = DATA_W'(msg_csum(w_m));
`endif
  end

endmodule

// File: rtl/msg_char_streamer.sv
// msg_char_streamer: streams one of NUM_MSG stored ASCII messages a byte at a time
// over valid/ready, with programmable idle gap (rate_div), one-shot/loop and stop.
// Ports: msg_sel/rate_div latched on start; char_out/char_valid/char_ready handshake;
// char_idx, busy, done status. MSG_CHECKSUM_EN appends an XOR checksum byte (CHK).
module msg_char_streamer
  import msg_streamer_pkg::*;
#(
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int NUM_MSG = DEF_NUM_MSG,
  parameter  int MAX_LEN = DEF_MAX_LEN,
  parameter  int PRESC_W = DEF_PRESC_W,
  localparam int SEL_W   = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1,
  localparam int IDX_W   = $clog2(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SEL_W-1:0]   msg_sel,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  input  logic [PRESC_W-1:0] rate_div,
  output logic [DATA_W-1:0]  char_out,
  output logic               char_valid,
  input  logic               char_ready,
  output logic [IDX_W-1:0]   char_idx,
  output logic               busy,
  output logic               done
);

  state_t               r_state, w_state_nxt, w_tgt;
  logic [SEL_W-1:0]     r_sel, w_sel_nxt;
  logic [PRESC_W-1:0]   r_rate, w_rate_nxt, r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic                 r_done, w_done_nxt;
  logic                 w_go, w_valid;
  logic [DATA_W-1:0]    w_rom_char;
  logic [IDX_W-1:0]     w_len;
  logic                 w_last;
`ifdef MSG_CHECKSUM_EN
  logic [DATA_W-1:0]    w_csum;
`endif

  msg_rom #(.DATA_W(DATA_W), .SEL_W(SEL_W), .IDX_W(IDX_W)) u_rom (
    .i_sel  (r_sel),
    .i_idx  (r_idx),
    .o_char (w_rom_char),
    .o_len  (w_len),
`ifdef MSG_CHECKSUM_EN
    .o_csum (w_csum),
`endif
    .o_last (w_last)
  );

`ifdef MSG_CHECKSUM_EN
  assign w_valid  = (r_state == S_SEND) || (r_state == S_CHK);
  assign char_out = !w_valid ? '0 : ((r_state == S_CHK) ? w_csum : w_rom_char);
`else
  assign w_valid  = (r_state == S_SEND);
  assign char_out = w_valid ? w_rom_char : '0;
`endif
  assign char_valid = w_valid;
  assign char_idx   = r_idx;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_rate  <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_rate  <= w_rate_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_rate_nxt  = r_rate;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    // w_go requests a move to w_tgt, routed through PACE when a gap is programmed.
    w_go        = 1'b0;
    w_tgt       = S_SEND;

    if (stop) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_sel_nxt   = (int'(msg_sel) >= NUM_MSG) ? '0 : msg_sel;
            w_rate_nxt  = rate_div;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = S_SEND;
          end
        end
        S_SEND: begin
          if (char_ready) begin
            if (!w_last) begin
              w_idx_nxt = r_idx + 1'b1;
              w_go      = 1'b1;
              w_tgt     = S_SEND;
            end else begin
`ifdef MSG_CHECKSUM_EN
              // idx == len marks the checksum slot, both in PACE and CHK.
              w_idx_nxt = w_len;
              w_go      = 1'b1;
              w_tgt     = S_CHK;
`else
              if (loop_en) begin
                w_idx_nxt = '0;
                w_go      = 1'b1;
                w_tgt     = S_SEND;
              end else begin
                w_idx_nxt   = '0;
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
              end
`endif
            end
          end
        end
        S_PACE: begin
          if (r_cnt == '0) begin
`ifdef MSG_CHECKSUM_EN
            w_state_nxt = (r_idx == w_len) ? S_CHK : S_SEND;
`else
            w_state_nxt = S_SEND;
`endif
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
`ifdef MSG_CHECKSUM_EN
        S_CHK: begin
          if (char_ready) begin
            w_idx_nxt = '0;
            if (loop_en) begin
              w_go  = 1'b1;
              w_tgt = S_SEND;
            end else begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
            end
          end
        end
`endif
        default: w_state_nxt = S_IDLE;
      endcase

      if (w_go) begin
        if (r_rate == '0) begin
          w_state_nxt = w_tgt;
        end else begin
          // PACE spends exactly r_rate cycles, so load rate-1.
          w_state_nxt = S_PACE;
          w_cnt_nxt   = r_rate - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_msg_char_streamer.sv
// tb_msg_char_streamer: directed + randomized bench comparing the streamer against
// a message-level reference model (expected byte stream, gaps, done/stop behaviour).
// Ports: drives all DUT inputs; checks char_out/char_valid/char_idx/busy/done.
module tb_msg_char_streamer;

  localparam int DATA_W  = 8;
  localparam int NUM_MSG = 4;
  localparam int MAX_LEN = 16;
  localparam int PRESC_W = 16;
  localparam int SEL_W   = 2;
  localparam int IDX_W   = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [SEL_W-1:0]   msg_sel;
  logic               start, stop, loop_en;
  logic [PRESC_W-1:0] rate_div;
  logic [DATA_W-1:0]  char_out;
  logic               char_valid, char_ready;
  logic [IDX_W-1:0]   char_idx;
  logic               busy, done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  string msgs [4] = '{"Guatemala", "Quetzal", "Zacapa", "SOY"};

  msg_char_streamer #(
    .DATA_W(DATA_W), .NUM_MSG(NUM_MSG), .MAX_LEN(MAX_LEN), .PRESC_W(PRESC_W)
  ) dut (
    .clk(clk), .reset(reset), .msg_sel(msg_sel), .start(start), .stop(stop),
    .loop_en(loop_en), .rate_div(rate_div), .char_out(char_out),
    .char_valid(char_valid), .char_ready(char_ready), .char_idx(char_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the stream is the message text, optionally followed by the
  // XOR of its characters, repeated when looping.
  function automatic int period(input int m);
`ifdef MSG_CHECKSUM_EN
    return msgs[m].len() + 1;
`else
    return msgs[m].len();
`endif
  endfunction

  function automatic logic [7:0] exp_byte(input int m, input int k);
    int pos;
    logic [7:0] x;
    pos = k % period(m);
    if (pos < msgs[m].len()) return msgs[m][pos];
    x = 8'h00;
    for (int i = 0; i < msgs[m].len(); i++) x = x ^ msgs[m][i];
    return x;
  endfunction

  // Plays message m; hold_k stalls ready for 5 cycles on that byte; stop_k raises
  // stop while that byte is presented (-1 = never).
  task automatic run_msg(input string tag, input int m, input int rate, input bit lp,
                         input int stall_pct, input int hold_k, input int stop_k);
    int  k = 0;
    int  acc_cyc;
    int  hold_left = 5;
    int  per;
    bit  fresh = 1'b1;
    bit  fin = 1'b0;
    bit  stop_now, last_acc, accepted;
    per      = period(m);
    msg_sel  = SEL_W'(m);
    rate_div = PRESC_W'(rate);
    loop_en  = lp;
    start    = 1'b1;
    stop     = 1'b0;
    char_ready = 1'b0;
    acc_cyc  = cyc;
    step();
    start    = 1'b0;
    rate_div = PRESC_W'($urandom);
    msg_sel  = SEL_W'($urandom);
    for (int n = 0; n < 4000 && !fin; n++) begin
      stop = 1'b0;
      if (char_valid) begin
        if (fresh) begin
          chk({tag, " gap"}, cyc - acc_cyc, (k == 0) ? 1 : rate + 1);
          fresh = 1'b0;
        end
        chk({tag, " char"}, char_out, exp_byte(m, k));
        chk({tag, " idx"}, char_idx, k % per);
        chk({tag, " busy"}, busy, 1);
        if (k == hold_k && hold_left > 0) begin
          char_ready = 1'b0;
          hold_left--;
        end else begin
          char_ready = ($urandom_range(0, 99) >= stall_pct);
        end
        if (k == stop_k) stop = 1'b1;
      end else begin
        char_ready = $urandom_range(0, 1);
      end
      start    = ($urandom_range(0, 7) == 0);
      accepted = char_valid && char_ready;
      stop_now = stop;
      last_acc = accepted && !lp && ((k % per) == per - 1);
      if (accepted) begin
        k++;
        acc_cyc = cyc;
        fresh   = 1'b1;
      end
      step();
      if (stop_now) begin
        start = 1'b0;
        stop  = 1'b0;
        chk({tag, " stop valid"}, char_valid, 0);
        chk({tag, " stop busy"}, busy, 0);
        chk({tag, " stop done"}, done, 0);
        fin = 1'b1;
      end else if (last_acc) begin
        start = 1'b0;
        chk({tag, " done"}, done, 1);
        chk({tag, " end busy"}, busy, 0);
        chk({tag, " end valid"}, char_valid, 0);
        step();
        chk({tag, " done pulse"}, done, 0);
        fin = 1'b1;
      end
    end
    chk({tag, " finished"}, fin, 1);
    start = 1'b0;
    stop = 1'b0;
    char_ready = 1'b0;
  endtask

  initial begin
    int m, per, stop_k;
    bit lp;
    reset = 1'b1; msg_sel = '0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    rate_div = '0; char_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("rst valid", char_valid, 0);
    chk("rst out", char_out, 0);
    chk("rst idx", char_idx, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);

    // Reset while presenting idx 4 of message 0.
    msg_sel = 0; rate_div = 0; start = 1'b1; char_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("mid idx", char_idx, 4);
    chk("mid char", char_out, exp_byte(0, 4));
    char_ready = 1'b0;
    reset = 1'b1;
    step();
    chk("arst valid", char_valid, 0);
    chk("arst out", char_out, 0);
    chk("arst idx", char_idx, 0);
    chk("arst busy", busy, 0);
    chk("arst done", done, 0);
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart valid", char_valid, 1);
    chk("restart char", char_out, 8'h47);
    chk("restart idx", char_idx, 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("abort busy", busy, 0);

    // start together with stop in IDLE is ignored.
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("startstop busy", busy, 0);
    chk("startstop valid", char_valid, 0);

    run_msg("zacapa", 2, 0, 1'b0, 0, -1, -1);
    run_msg("soy_rate3", 3, 3, 1'b0, 0, -1, -1);
    run_msg("quetzal_hold", 1, 0, 1'b0, 0, 2, -1);
    run_msg("soy_loop", 3, 0, 1'b1, 0, -1, period(3) + 1);
    run_msg("guat_rate20", 0, 20, 1'b0, 30, -1, -1);

    for (int it = 0; it < 20; it++) begin
      m   = $urandom_range(0, 3);
      lp  = $urandom_range(0, 1);
      per = period(m);
      if (lp) stop_k = $urandom_range(0, 3 * per);
      else if ($urandom_range(0, 3) == 0) stop_k = $urandom_range(0, per - 1);
      else stop_k = -1;
      run_msg($sformatf("rnd%0d", it), m, $urandom_range(0, 4), lp,
              $urandom_range(0, 60), $urandom_range(0, per - 1), stop_k);
      for (int g = 0; g < $urandom_range(0, 3); g++) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
